// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches a full-precision result at issue,
// holds busy for a fixed latency, then commits it to the architectural HI/LO pair.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi_nxt;
  logic [31:0]   r_lo_nxt;

  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Full 64-bit product; the low 64 bits of the extended operands' product are exact.
  always_comb begin
    if (md_op == OP_MULT) begin
      w_a_ext = {{32{A[31]}}, A};
      w_b_ext = {{32{B[31]}}, B};
    end else begin
      w_a_ext = {32'd0, A};
      w_b_ext = {32'd0, B};
    end
    w_prod = w_a_ext * w_b_ext;
  end

  // Signed divide via magnitudes: INT_MIN / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    w_div_signed = (md_op == OP_DIV);
    w_a_neg      = w_div_signed & A[31];
    w_b_neg      = w_div_signed & B[31];
    w_a_mag      = w_a_neg ? (32'd0 - A) : A;
    w_b_mag      = w_b_neg ? (32'd0 - B) : B;
    if (w_b_mag != 32'd0) begin
      w_uq = w_a_mag / w_b_mag;
      w_ur = w_a_mag % w_b_mag;
    end else begin
      w_uq = 32'd0;
      w_ur = 32'd0;
    end
    w_quot = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    w_rem  = w_a_neg ? (32'd0 - w_ur) : w_ur;
  end

  // Control FSM, countdown, staged result and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi_nxt <= 32'd0;
      r_lo_nxt <= 32'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                r_hi_nxt <= w_prod[63:32];
                r_lo_nxt <= w_prod[31:0];
                r_cnt    <= CW'(MULT_CYCLES);
                r_state  <= ST_MUL;
                busy     <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor re-commits the current HI/LO so nothing changes.
                r_hi_nxt <= (B == 32'd0) ? HI : w_rem;
                r_lo_nxt <= (B == 32'd0) ? LO : w_quot;
                r_cnt    <= CW'(DIV_CYCLES);
                r_state  <= ST_DIV;
                busy     <= 1'b1;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt == CW'(1)) begin
            HI      <= r_hi_nxt;
            LO      <= r_lo_nxt;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Move-from read port, deliberately not gated by busy.
  always_comb begin
    case (md_op)
      OP_MFHI: md_out = HI;
      OP_MFLO: md_out = LO;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random ops
// against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .start(start), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result of an op on (a,b) given current HI/LO, and its latency.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int si, sj;
    hi = m_hi; lo = m_lo; lat = 0;
    case (op)
      4'd1: begin sa = $signed(a); sb = $signed(b); sp = sa * sb;
              hi = sp[63:32]; lo = sp[31:0]; lat = MC; end
      4'd2: begin ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub;
              hi = up[63:32]; lo = up[31:0]; lat = MC; end
      4'd3: begin
        lat = DC;
        if (b == 32'd0) begin end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 32'd0; end
        else begin si = $signed(a); sj = $signed(b); lo = si / sj; hi = si % sj; end
      end
      4'd4: begin lat = DC; if (b != 32'd0) begin lo = a / b; hi = a % b; end end
      4'd7: hi = a;
      4'd8: lo = a;
      default: ;
    endcase
  endtask

  // Issue one op at the next edge (caller is #1 after an edge) and check it end to end.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    int lat, cnt;
    model(op, a, b, ehi, elo, lat);
    md_op = op; A = a; B = b; start = 1'b1;
    if (op == 4'd5 || op == 4'd6) begin
      #1;
      chk({tag, "_mdout"}, {32'd0, md_out}, {32'd0, (op == 4'd5) ? m_hi : m_lo});
    end
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      chk({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
      @(posedge clk); #1;
    end
    chk({tag, "_busycyc"}, 64'(cnt), 64'(lat));
    m_hi = ehi; m_lo = elo;
    chk({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    int lat, cnt;
    logic [3:0] rop;

    reset = 1'b0; start = 1'b0; md_op = 4'd5; A = 32'd0; B = 32'd0;
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_mdout", {32'd0, md_out}, 64'd0);
    md_op = 4'd0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    do_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_ref", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    do_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
    chk("multu_ref", {HI, LO}, 64'h00000002_FFFFFFFA);
    do_op("div",   4'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_ref", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("divu",  4'd4, 32'd7, 32'd2);
    chk("divu_ref", {HI, LO}, 64'h00000001_00000003);
    do_op("mthi",  4'd7, 32'h11111111, 32'd0);
    do_op("mtlo",  4'd8, 32'h22222222, 32'd0);
    do_op("div0",  4'd3, 32'd1234, 32'd0);
    chk("div0_ref", {HI, LO}, 64'h11111111_22222222);
    do_op("intmin", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("intmin_ref", {HI, LO}, 64'h00000000_80000000);

    // MULT presented during cycle 2 of a DIV must be dropped.
    model(4'd3, 32'd100, 32'd7, ehi, elo, lat);
    md_op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    @(posedge clk); #1;
    md_op = 4'd1; A = 32'd9; B = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    cnt = 2;
    while (busy && cnt < 40) begin cnt++; @(posedge clk); #1; end
    chk("haz_busycyc", 64'(cnt), 64'(DC));
    m_hi = ehi; m_lo = elo;
    chk("haz_hilo", {HI, LO}, {m_hi, m_lo});
    repeat (MC + 1) begin @(posedge clk); #1; end
    chk("haz_nomult", {63'd0, busy}, 64'd0);
    chk("haz_hilo2", {HI, LO}, 64'h00000002_0000000E);

    do_op("mtlo2", 4'd8, 32'h12345678, 32'd0);
    do_op("mflo",  4'd6, 32'd0, 32'd0);
    chk("mflo_val", {32'd0, LO}, 64'h12345678);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 8))
        0: rop = 4'd1; 1: rop = 4'd2; 2: rop = 4'd3; 3: rop = 4'd4;
        4: rop = 4'd5; 5: rop = 4'd6; 6: rop = 4'd7; 7: rop = 4'd8;
        default: rop = 4'(12 + $urandom_range(0, 3));
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      do_op("rnd", rop, ra, rb);
    end

    // Asynchronous reset landing mid-MULT clears everything immediately.
    md_op = 4'd1; A = 32'd12345; B = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0; #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hilo", {HI, LO}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); reset = 1'b1;
    md_op = 4'd5; #1;
    chk("arst_mfhi", {32'd0, md_out}, 64'd0);
    @(posedge clk); #1;
    md_op = 4'd0;
    do_op("post_rst", 4'd2, 32'hDEADBEEF, 32'h00010001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port md_op  input  4  decoded op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others treated as NONE.
REQ-006 SHALL have port start  input  1  E-stage instruction valid qualifier for md_op.
REQ-007 SHALL have port A  input  32  rs operand (forwarded).
REQ-008 SHALL have port B  input  32  rt operand (forwarded).
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.
REQ-012 SHALL have port md_out  output  32  value for MFHI/MFLO writeback.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1 and md_op in {MULT,MULTU}, latch result of A*B (64-bit, signed for MULT, unsigned for MULTU) into internal hi_nxt/lo_nxt, load counter with MULT_CYCLES, go to MUL.
REQ-015 SHALL, in IDLE with start=1 and md_op in {DIV,DIVU}, latch quotient to lo_nxt and remainder to hi_nxt, load counter with DIV_CYCLES, go to DIV.
REQ-016 SHALL divide signed (DIV) truncating toward zero, remainder sign equal to dividend sign; DIVU unsigned.
REQ-017 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0x00000000.
REQ-018 SHALL, for divisor B=0, run the full DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-019 SHALL assert busy=1 in MUL/DIV only; start sampled at edge k gives busy=1 for cycles after edges k..k+N-1 (exactly N cycles).
REQ-020 SHALL decrement counter each cycle in MUL/DIV; on counter reaching 1, commit hi_nxt/lo_nxt to HI/LO on that edge and return to IDLE (busy=0 after edge k+N).
REQ-021 SHALL keep HI/LO visible values unchanged during MUL/DIV (no partial result exposure).
REQ-022 SHALL ignore start with any md_op while busy=1 (hazard unit stalls; block does not queue).
REQ-023 SHALL, in IDLE with start=1, write HI<=A on MTHI and LO<=A on MTLO at that edge; no busy.
REQ-024 SHALL drive md_out combinationally: HI when md_op=MFHI, LO when md_op=MFLO, else 0, independent of busy.
REQ-025 SHALL ignore start=0 and md_op=NONE/undefined without state change.
REQ-026 SHALL hold counter width sufficient for max(MULT_CYCLES, DIV_CYCLES); parameters >= 1.

Reset
REQ-027 SHALL, on reset low at any time including mid-operation, immediately force state IDLE, busy=0, counter=0, HI=LO=hi_nxt=lo_nxt=0.
REQ-028 SHALL, on reset release, accept start on the first rising edge thereafter.

Verification
REQ-029 SHALL cover MULT A=0xFFFFFFFE, B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
REQ-031 SHALL cover DIV B=0 with HI=0x11111111, LO=0x22222222 preloaded via MTHI/MTLO -> busy 10 cycles, HI/LO unchanged; INT_MIN/-1 -> LO=0x80000000, HI=0.
REQ-032 SHALL cover start=1 md_op=MULT issued on cycle 2 of a running DIV -> ignored, DIV result committed at cycle 10, busy falls once.
REQ-033 SHALL cover reset asserted on cycle 3 of MULT -> busy=0, HI=LO=0 immediately; MFHI after release -> md_out=0.
REQ-034 SHALL cover MTLO A=0x12345678 then MFLO next cycle -> md_out=0x12345678, busy never asserted.
